mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multicycle MIPS-subset control FSM. It is the successor to the current hard-wired control unit.
- Memory wait states come from a parameterised counter instead of duplicated states.
- Adds jal, jr, an explicit load write-back state and a halt indicator.
- Drives the datapath muxes/enables for PC, IR, MDR, A, B, ALUOut and the register file. Sits between the instruction register fields and the datapath.

Parameters:
MEM_WAIT, 2, extra cycles each memory access is held (access lasts MEM_WAIT+1 cycles); 0 legal
CNT_W, $clog2(MEM_WAIT+1) (min 1), width of wait counter

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_write  out  1  PC load enable
iord  out  1  mem address: 0 PC, 1 ALUOut
mem_write  out  1  1 write, 0 read
ir_write  out  1  IR load
mdr_write  out  1  MDR load
a_write  out  1  A load
b_write  out  1  B load
alu_out_write  out  1  ALUOut load
reg_write  out  1  register-file write
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 imm<<16, 3 PC
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  0 B, 1 const 4, 2 sext imm, 3 sext imm<<2
pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 A
alu_op  out  3  LOAD0 ADD1 SUB2 AND3 INC4 NEG5 XOR6 COMP7
state_out  out  4  current state encoding
halted  out  1  1 in HALT
illegal  out  1  illegal-instruction pulse (see Optional Feature)

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset: state=FETCH, cnt=0.
  - Outputs are the FETCH cnt=0 values: alu_src_b=1, alu_op=ADD; every other output 0.
- Outputs are Moore-style from (state, cnt, opcode, funct, zero). No X outputs; unlisted outputs are 0.
- State encodings: FETCH0 DECODE1 R_EXEC2 R_WB3 MEM_ADDR4 MEM_RD5 LW_WB6 MEM_WR7 BRANCH8 LUI9 JUMP10 JAL11 JR12 HALT13 TRAP14.
- Wait counter applies in FETCH, MEM_RD and MEM_WR only.
  - cnt increments each cycle while cnt<MEM_WAIT.
  - The state exits when cnt==MEM_WAIT; cnt clears to 0 on exit.
  - cnt stays 0 in all other states.
- FETCH: iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. On the last cycle (cnt==MEM_WAIT) only: ir_write=1, pc_write=1, pc_source=0. Then -> DECODE.
- DECODE: a_write=b_write=1, alu_out_write=1, alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target). Dispatch:
  - op 0x00: funct 0x20/0x22/0x24/0x26 -> R_EXEC; 0x08 -> JR; 0x0D -> HALT; 0x00 (nop) -> FETCH; other -> FETCH
  - op 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x0F -> LUI; 0x02 -> JUMP; 0x03 -> JAL; other -> FETCH
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_out_write=1, alu_op from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR). -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD, alu_out_write=1. -> MEM_RD if op 0x23, else MEM_WR.
- MEM_RD: iord=1, mdr_write=1, held MEM_WAIT+1 cycles. -> LW_WB.
- LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEM_WR: iord=1, mem_write=1, held MEM_WAIT+1 cycles. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1. pc_write=zero for op 0x04, ~zero for 0x05. -> FETCH.
- LUI: reg_write=1, reg_dst=0, mem_to_reg=2. -> FETCH.
- JUMP: pc_write=1, pc_source=2. -> FETCH.
- JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=3. The PC written to $31 is already PC+4. -> FETCH.
- JR: pc_write=1, pc_source=3. -> FETCH.
- HALT: halted=1, all enables 0. Stays until reset.
- Opcode/funct are sampled combinationally each cycle; IR is stable after FETCH.
- Reset asserted in any state, including mid-wait, forces FETCH with cnt=0 asynchronously. Any partial memory access is abandoned.
- MEM_WAIT=0: FETCH, MEM_RD and MEM_WR are single-cycle.

Optional Feature:
MC_CU_ILLEGAL_TRAP_EN
- Defined:
  - DECODE's "other" cases (undefined opcode, or undefined funct with op 0x00) -> TRAP.
  - TRAP asserts illegal=1 for exactly one cycle, all enables 0. -> HALT.
- Undefined: undefined instructions -> FETCH (skipped as nop); illegal tied 0; TRAP unreachable.

Test Plan:
- MEM_WAIT=2, reset released, op 0x00 funct 0x20 -> FETCH 3 cycles (ir_write/pc_write only on 3rd), DECODE, R_EXEC alu_op=1, R_WB reg_write=1 reg_dst=1; 6 cycles total.
- lw (0x23) then sw (0x2B), MEM_WAIT=2 -> MEM_RD mdr_write 3 cycles then LW_WB mem_to_reg=1; MEM_WR mem_write=1 for exactly 3 cycles.
- beq op 0x04 zero=1 -> pc_write=1 pc_source=1 in BRANCH; zero=0 -> pc_write=0; bne op 0x05 zero=0 -> pc_write=1.
- jal op 0x03 -> reg_dst=2 mem_to_reg=3 pc_source=2 pc_write=1; jr funct 0x08 -> pc_source=3 pc_write=1.
- funct 0x0D -> HALT, halted=1 held 20 cycles; reset during MEM_RD cnt=1 -> state_out=0 immediately, cnt=0.
- op 0x3F: without MC_CU_ILLEGAL_TRAP_EN -> next state FETCH; with it -> TRAP, one-cycle illegal=1, then HALT.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM. Memory accesses in FETCH, MEM_RD and MEM_WR
// are stretched by a wait counter to MEM_WAIT+1 cycles. Outputs are decoded from
// the current state, wait count, instruction fields and the ALU zero flag.
// Optional build macro: MC_CU_ILLEGAL_TRAP_EN routes undefined instructions
// through a one-cycle TRAP state into HALT instead of skipping them.
module mc_control_unit #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state_out,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StRExec   = 4'd2,
        StRWb     = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StLwWb    = 4'd6,
        StMemWr   = 4'd7,
        StBranch  = 4'd8,
        StLui     = 4'd9,
        StJump    = 4'd10,
        StJal     = 4'd11,
        StJr      = 4'd12,
        StHalt    = 4'd13,
        StTrap    = 4'd14
    } state_e;

    localparam logic [2:0] AluLoad = 3'd0;
    localparam logic [2:0] AluAdd  = 3'd1;
    localparam logic [2:0] AluSub  = 3'd2;
    localparam logic [2:0] AluAnd  = 3'd3;
    localparam logic [2:0] AluXor  = 3'd6;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MEM_WAIT);

`ifdef MC_CU_ILLEGAL_TRAP_EN
    localparam state_e StUndef = StTrap;
`else
    localparam state_e StUndef = StFetch;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_done;

    assign wait_done = (cnt_q == CntMax);

    // State and wait-counter registers; reset abandons any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: memory states hold until the counter reaches MEM_WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StFetch, StMemRd, StMemWr: begin
                if (!wait_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    unique case (state_q)
                        StFetch: state_d = StDecode;
                        StMemRd: state_d = StLwWb;
                        default: state_d = StFetch;
                    endcase
                end
            end
            StDecode: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24, 6'h26: state_d = StRExec;
                            6'h08:                      state_d = StJr;
                            6'h0D:                      state_d = StHalt;
                            6'h00:                      state_d = StFetch;
                            default:                    state_d = StUndef;
                        endcase
                    end
                    6'h23, 6'h2B: state_d = StMemAddr;
                    6'h04, 6'h05: state_d = StBranch;
                    6'h0F:        state_d = StLui;
                    6'h02:        state_d = StJump;
                    6'h03:        state_d = StJal;
                    default:      state_d = StUndef;
                endcase
            end
            StRExec:   state_d = StRWb;
            StMemAddr: state_d = (opcode == 6'h23) ? StMemRd : StMemWr;
            StHalt:    state_d = StHalt;
            StTrap:    state_d = StHalt;
            default:   state_d = StFetch;
        endcase
    end

    // Datapath controls decoded from the current state (Moore-style).
    always_comb begin
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        alu_op        = AluLoad;
        halted        = 1'b0;
        illegal       = 1'b0;
        unique case (state_q)
            StFetch: begin
                alu_src_b = 2'd1;
                alu_op    = AluAdd;
                // Commit PC+4 and the fetched word only once the read completes.
                ir_write  = wait_done;
                pc_write  = wait_done;
            end
            StDecode: begin
                a_write       = 1'b1;
                b_write       = 1'b1;
                alu_out_write = 1'b1;
                alu_src_b     = 2'd3;
                alu_op        = AluAdd;
            end
            StRExec: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                case (funct)
                    6'h22:   alu_op = AluSub;
                    6'h24:   alu_op = AluAnd;
                    6'h26:   alu_op = AluXor;
                    default: alu_op = AluAdd;
                endcase
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
            end
            StMemAddr: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'd2;
                alu_op        = AluAdd;
                alu_out_write = 1'b1;
            end
            StMemRd: begin
                iord      = 1'b1;
                mdr_write = 1'b1;
            end
            StLwWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = 2'd1;
                pc_write  = (opcode == 6'h05) ? ~zero : zero;
            end
            StLui: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd2;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            StJal: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd3;
            end
            StJr: begin
                pc_write  = 1'b1;
                pc_source = 2'd3;
            end
            StHalt: halted = 1'b1;
            StTrap: begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: each instruction is expanded by a
// reference model into the expected per-cycle control trace and compared cycle by cycle.
module tb_mc_control_unit;

    localparam int MW = 2;

    logic       clock, reset, zero;
    logic [5:0] opcode, funct;
    logic       pc_write, iord, mem_write, ir_write, mdr_write, a_write, b_write;
    logic       alu_out_write, reg_write, alu_src_a, halted, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_out;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, iord, mem_write, ir_write, mdr_write, a_write, b_write;
        logic       alu_out_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic [2:0] alu_op;
        logic       halted, illegal;
    } ctl_t;

    ctl_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    mc_control_unit #(.MEM_WAIT(MW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .a_write(a_write), .b_write(b_write),
        .alu_out_write(alu_out_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_op(alu_op), .state_out(state_out),
        .halted(halted), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ctl_t fetch_vec(input bit last);
        ctl_t e = '0;
        e.alu_src_b = 2'd1;
        e.alu_op    = 3'd1;
        e.ir_write  = last;
        e.pc_write  = last;
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        ctl_t obs;
        obs = {state_out, pc_write, iord, mem_write, ir_write, mdr_write, a_write, b_write,
               alu_out_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               pc_source, alu_op, halted, illegal};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: expands one instruction into its sequence of control words.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         output bit ends_halt);
        ctl_t e;
        ends_halt = 0;
        exp_q.delete();
        for (int i = 0; i <= MW; i++) exp_q.push_back(fetch_vec(i == MW));
        e = '0; e.st = 4'd1; e.a_write = 1; e.b_write = 1; e.alu_out_write = 1;
        e.alu_src_b = 2'd3; e.alu_op = 3'd1;
        exp_q.push_back(e);
        e = '0;
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h26}) begin
            e.st = 4'd2; e.alu_src_a = 1; e.alu_out_write = 1;
            e.alu_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd6;
            exp_q.push_back(e);
            e = '0; e.st = 4'd3; e.reg_write = 1; e.reg_dst = 2'd1;
            exp_q.push_back(e);
        end else if (op == 6'h00 && fn == 6'h08) begin
            e.st = 4'd12; e.pc_write = 1; e.pc_source = 2'd3;
            exp_q.push_back(e);
        end else if (op == 6'h00 && fn == 6'h0D) begin
            e.st = 4'd13; e.halted = 1;
            for (int i = 0; i < 20; i++) exp_q.push_back(e);
            ends_halt = 1;
        end else if (op == 6'h00 && fn == 6'h00) begin
            // nop: straight back to fetch
        end else if (op == 6'h23 || op == 6'h2B) begin
            e.st = 4'd4; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 3'd1;
            e.alu_out_write = 1;
            exp_q.push_back(e);
            e = '0; e.iord = 1;
            if (op == 6'h23) begin
                e.st = 4'd5; e.mdr_write = 1;
            end else begin
                e.st = 4'd7; e.mem_write = 1;
            end
            for (int i = 0; i <= MW; i++) exp_q.push_back(e);
            if (op == 6'h23) begin
                e = '0; e.st = 4'd6; e.reg_write = 1; e.mem_to_reg = 2'd1;
                exp_q.push_back(e);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            e.st = 4'd8; e.alu_src_a = 1; e.alu_op = 3'd2; e.pc_source = 2'd1;
            e.pc_write = (op == 6'h04) ? z : !z;
            exp_q.push_back(e);
        end else if (op == 6'h0F) begin
            e.st = 4'd9; e.reg_write = 1; e.mem_to_reg = 2'd2;
            exp_q.push_back(e);
        end else if (op == 6'h02) begin
            e.st = 4'd10; e.pc_write = 1; e.pc_source = 2'd2;
            exp_q.push_back(e);
        end else if (op == 6'h03) begin
            e.st = 4'd11; e.pc_write = 1; e.pc_source = 2'd2; e.reg_write = 1;
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd3;
            exp_q.push_back(e);
        end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
            e.st = 4'd14; e.illegal = 1;
            exp_q.push_back(e);
            e = '0; e.st = 4'd13; e.halted = 1;
            for (int i = 0; i < 5; i++) exp_q.push_back(e);
            ends_halt = 1;
`endif
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH cnt=0; leaves it there for the next call.
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_hold", fetch_vec(MW == 0));
        reset = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stop_at);
        bit h;
        int n;
        opcode = op; funct = fn; zero = z;
        model(op, fn, z, h);
        n = (stop_at >= 0) ? stop_at : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check($sformatf("%s_c%0d", tag, i), exp_q[i]);
            @(posedge clock); #1;
        end
        if (stop_at < 0 && h) apply_reset();
    endtask

    logic [5:0] op_tab[9];
    logic [5:0] fn_tab[7];

    initial begin
        op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02, 6'h03, 6'h3F};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h08, 6'h00, 6'h0D};
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        #1;
        check("reset_state", fetch_vec(MW == 0));
        @(posedge clock); #1;
        reset = 1'b0;

        run_instr("add", 6'h00, 6'h20, 1'b0, -1);
        run_instr("lw", 6'h23, 6'h00, 1'b0, -1);
        run_instr("sw", 6'h2B, 6'h00, 1'b0, -1);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, -1);
        run_instr("bne_taken", 6'h05, 6'h00, 1'b0, -1);
        run_instr("jal", 6'h03, 6'h00, 1'b0, -1);
        run_instr("jr", 6'h00, 6'h08, 1'b0, -1);
        run_instr("halt", 6'h00, 6'h0D, 1'b0, -1);

        // Abort a load while MEM_RD is in its second wait cycle.
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, MW + 4);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", fetch_vec(MW == 0));
        @(posedge clock); #1;
        reset = 1'b0;
        run_instr("after_abort", 6'h0F, 6'h00, 1'b0, -1);

        run_instr("undef_op", 6'h3F, 6'h00, 1'b0, -1);
        run_instr("undef_fn", 6'h00, 6'h3E, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            logic [5:0] op, fn;
            op = op_tab[$urandom_range(0, 8)];
            fn = (op == 6'h00) ? fn_tab[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
            if (op == 6'h3F) op = 6'($urandom_range(0, 63));
            run_instr($sformatf("rnd%0d_op%h_fn%h", k, op, fn), op, fn,
                      1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
